// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatch stage.
// Contents: FSM state enum, bus/channel geometry and the vector-ID helper.
package irq_dispatch_pkg;

    localparam int unsigned NUM_BUS    = 3;
    localparam int unsigned CH_PER_BUS = 9;
    localparam int unsigned NUM_VEC    = 27;
    localparam int unsigned VEC_W      = 5;

    typedef enum logic [1:0] {
        StIdle,
        StQualify,
        StPresent,
        StService
    } state_e;

    // Vector ID = bus * CH_PER_BUS + chan, with bus A=0, B=1, C=2.
    function automatic logic [VEC_W-1:0] calc_vec(input logic [1:0] bus,
                                                   input logic [3:0] chan);
        logic [VEC_W-1:0] v;
        v = VEC_W'(bus) * VEC_W'(CH_PER_BUS) + VEC_W'(chan);
        return v;
    endfunction

endpackage

// File: rtl/irq_stable_filter.sv
// Stable-sample qualifier for the encoder outputs.
// Registers {pa,pb,pc,~chan_n} every cycle, compares against the previous
// sample and counts consecutive identical samples while the FSM qualifies.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   pa, pb, pc      encoder bus-win flags
//   chan_n          active-low channel index within the winning bus
//   start           FSM is leaving IDLE for QUALIFY (load count with 1)
//   qual_en         FSM is in QUALIFY
//   legal           registered sample holds a request with chan 0..8
//   qualified       sample has been stable for STABLE_CYCLES samples
//   vec             vector ID decoded from the registered sample
//   err_chan        one-cycle pulse on entry into a request with chan > 8
module irq_stable_filter
    import irq_dispatch_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pa,
    input  logic             pb,
    input  logic             pc,
    input  logic [3:0]       chan_n,
    input  logic             start,
    input  logic             qual_en,
    output logic             legal,
    output logic             qualified,
    output logic [VEC_W-1:0] vec,
    output logic             err_chan
);

    localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

    logic [6:0] samp_q;
    logic [6:0] prev_q;
    logic [3:0] stab_cnt_q;
    logic       bad_q;

    logic       req;
    logic       chan_bad;
    logic       same;
    logic [1:0] bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= '0;
            prev_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            samp_q <= {pa, pb, pc, ~chan_n};
            prev_q <= samp_q;
            bad_q  <= chan_bad;
        end
    end

    always_comb begin
        req      = |samp_q[6:4];
        chan_bad = req && (samp_q[3:0] > 4'd8);
        legal    = req && !chan_bad;
        same     = (samp_q == prev_q);
        bus      = samp_q[6] ? 2'd0 : (samp_q[5] ? 2'd1 : 2'd2);
        vec      = calc_vec(bus, samp_q[3:0]);
        err_chan = chan_bad && !bad_q;
        // Stable count is only advanced by an equal compare, so require one here too.
        qualified = qual_en && legal && same && (stab_cnt_q == StableCnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt_q <= '0;
        end else if (start) begin
            stab_cnt_q <= 4'd1;
        end else if (qual_en) begin
            if (!same) begin
                stab_cnt_q <= 4'd1;
            end else if (stab_cnt_q < StableCnt) begin
                stab_cnt_q <= stab_cnt_q + 4'd1;
            end
        end else begin
            stab_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/irq_dispatch_seq.sv
// Interrupt dispatch stage behind the 27-channel priority encoder.
// Qualifies encoder requests, presents a 5-bit vector with valid/ready and
// holds a one-hot in-service mask until end-of-interrupt.
// Optional feature macro: IRQ_TIMEOUT_EN (forced release after TIMEOUT
// cycles in SERVICE, sticky timeout flag).
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pa, pb, pc, chan_n  encoder outputs (chan_n active low)
//   irq_valid/irq_ready vector handshake towards the CPU
//   irq_vec             latched vector ID (bus*9 + chan)
//   eoi                 end-of-interrupt pulse
//   svc_mask            one-hot in-service channel
//   busy                FSM not idle
//   err_chan            pulse on request with illegal channel
//   timeout             sticky forced-release flag (0 without the feature)
module irq_dispatch_seq
    import irq_dispatch_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pa,
    input  logic               pb,
    input  logic               pc,
    input  logic [3:0]         chan_n,
    output logic               irq_valid,
    input  logic               irq_ready,
    output logic [VEC_W-1:0]   irq_vec,
    input  logic               eoi,
    output logic [NUM_VEC-1:0] svc_mask,
    output logic               busy,
    output logic               err_chan,
    output logic               timeout
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q;
    logic [NUM_VEC-1:0] svc_q;

    logic             legal;
    logic             qualified;
    logic [VEC_W-1:0] vec;
    logic             start;
    logic             qual_en;
    logic             take_hs;
    logic             tmo_hit;
    logic             release_svc;

    irq_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .pa        (pa),
        .pb        (pb),
        .pc        (pc),
        .chan_n    (chan_n),
        .start     (start),
        .qual_en   (qual_en),
        .legal     (legal),
        .qualified (qualified),
        .vec       (vec),
        .err_chan  (err_chan)
    );

    always_comb begin
        start       = (state_q == StIdle) && legal;
        qual_en     = (state_q == StQualify);
        take_hs     = (state_q == StPresent) && irq_ready;
        // eoi wins over a same-cycle timeout.
        release_svc = (state_q == StService) && (eoi || tmo_hit);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (legal) state_d = StQualify;
            StQualify: begin
                if (!legal) begin
                    state_d = StIdle;
                end else if (qualified) begin
                    state_d = StPresent;
                end
            end
            StPresent: if (irq_ready) state_d = StService;
            StService: if (release_svc) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        irq_valid = (state_q == StPresent);
        busy      = (state_q != StIdle);
        irq_vec   = vec_q;
        svc_mask  = svc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            svc_q <= '0;
        end else begin
            if (qualified) begin
                vec_q <= vec;
            end
            if (take_hs) begin
                svc_q <= NUM_VEC'(1) << vec_q;
            end else if (release_svc) begin
                svc_q <= '0;
            end
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            tmo_q;

    // Hit on the TIMEOUT-th cycle spent in SERVICE.
    assign tmo_hit = (state_q == StService) && (tmo_cnt_q == TmoW'(TIMEOUT - 1));
    assign timeout = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (take_hs) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StService) begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end
            if (tmo_hit && !eoi) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_param;

    assign unused_timeout_param = ^32'(TIMEOUT);
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Directed self-checking bench for irq_dispatch_seq (STABLE_CYCLES=2, TIMEOUT=8).
module tb_irq_dispatch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        pa, pb, pc;
    logic [3:0]  chan_n;
    logic        irq_valid;
    logic        irq_ready;
    logic [4:0]  irq_vec;
    logic        eoi;
    logic [26:0] svc_mask;
    logic        busy;
    logic        err_chan;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_dispatch_seq #(
        .STABLE_CYCLES (2),
        .TIMEOUT       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pa        (pa),
        .pb        (pb),
        .pc        (pc),
        .chan_n    (chan_n),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_vec   (irq_vec),
        .eoi       (eoi),
        .svc_mask  (svc_mask),
        .busy      (busy),
        .err_chan  (err_chan),
        .timeout   (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(irq_valid), 32'd0);
        check_eq({tag, "_vec"},   32'(irq_vec),   32'd0);
        check_eq({tag, "_svc"},   32'(svc_mask),  32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_err"},   32'(err_chan),  32'd0);
        check_eq({tag, "_tmo"},   32'(timeout),   32'd0);
    endtask

    initial begin
        rst = 1'b1; pa = 1'b0; pb = 1'b0; pc = 1'b0; chan_n = 4'hF;
        irq_ready = 1'b0; eoi = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // Basic dispatch: bus B, chan 3 -> vec 12, valid after edge 3.
        rst = 1'b0; pb = 1'b1; chan_n = 4'b1100;
        tick();
        check_eq("basic_e0_valid", 32'(irq_valid), 32'd0);
        tick();
        check_eq("basic_e1_busy", 32'(busy), 32'd1);
        tick();
        check_eq("basic_e2_valid", 32'(irq_valid), 32'd0);
        tick();
        check_eq("basic_e3_valid", 32'(irq_valid), 32'd1);
        check_eq("basic_e3_vec", 32'(irq_vec), 32'd12);
        // ready and eoi together in PRESENT: only the handshake counts.
        irq_ready = 1'b1; eoi = 1'b1; pb = 1'b0;
        tick();
        check_eq("basic_hs_valid", 32'(irq_valid), 32'd0);
        check_eq("basic_hs_svc", 32'(svc_mask), 32'h0000_1000);
        check_eq("basic_hs_busy", 32'(busy), 32'd1);
        irq_ready = 1'b0;
        tick();
        check_eq("basic_eoi_svc", 32'(svc_mask), 32'd0);
        check_eq("basic_eoi_busy", 32'(busy), 32'd0);
        eoi = 1'b0;
        tick();

        // Glitch rejection: pa toggles every cycle.
        chan_n = 4'hF;
        for (int i = 0; i < 10; i++) begin
            pa = ~i[0];
            tick();
            check_eq("glitch_valid", 32'(irq_valid), 32'd0);
            if (i >= 1) check_eq("glitch_busy", 32'(busy), 32'(i[0]));
        end
        pa = 1'b0;
        tick();
        tick();
        check_eq("glitch_end_busy", 32'(busy), 32'd0);

        // Held vector: vec 0 presented, inputs then change to bus C chan 8.
        pa = 1'b1; chan_n = 4'hF;
        repeat (4) tick();
        check_eq("held_valid", 32'(irq_valid), 32'd1);
        check_eq("held_vec0", 32'(irq_vec), 32'd0);
        pa = 1'b0; pc = 1'b1; chan_n = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            eoi = (i == 2);
            tick();
            check_eq("held_hold_valid", 32'(irq_valid), 32'd1);
            check_eq("held_hold_vec", 32'(irq_vec), 32'd0);
        end
        eoi = 1'b0; irq_ready = 1'b1;
        tick();
        check_eq("held_hs_svc", 32'(svc_mask), 32'd1);
        irq_ready = 1'b0; pc = 1'b0;
        repeat (3) tick();
        check_eq("held_svc_hold", 32'(svc_mask), 32'd1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check_eq("held_rel_svc", 32'(svc_mask), 32'd0);
        check_eq("held_rel_busy", 32'(busy), 32'd0);
        tick();

        // Illegal channel: bus A chan 9.
        pa = 1'b1; chan_n = 4'b0110;
        tick();
        check_eq("illegal_err1", 32'(err_chan), 32'd1);
        check_eq("illegal_busy1", 32'(busy), 32'd0);
        tick();
        check_eq("illegal_err2", 32'(err_chan), 32'd0);
        tick();
        check_eq("illegal_busy3", 32'(busy), 32'd0);
        check_eq("illegal_valid3", 32'(irq_valid), 32'd0);
        pa = 1'b0; chan_n = 4'hF;
        tick();
        tick();

        // Reset mid-service with vec 26 (bus C chan 8).
        pc = 1'b1; chan_n = 4'b0111;
        repeat (4) tick();
        check_eq("rst_pre_vec", 32'(irq_vec), 32'd26);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check_eq("rst_pre_svc", 32'(svc_mask), 32'h0400_0000);
        rst = 1'b1; eoi = 1'b1;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b0; eoi = 1'b0;
        // Request still held: full requalification needed.
        tick();
        tick();
        tick();
        check_eq("rst_requal_e2", 32'(irq_valid), 32'd0);
        tick();
        check_eq("rst_requal_e3", 32'(irq_valid), 32'd1);
        check_eq("rst_requal_vec", 32'(irq_vec), 32'd26);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;

`ifdef IRQ_TIMEOUT_EN
        // Timeout: request still held, no eoi.
        repeat (7) tick();
        check_eq("tmo_pre_svc", 32'(svc_mask), 32'h0400_0000);
        check_eq("tmo_pre_flag", 32'(timeout), 32'd0);
        tick();
        check_eq("tmo_svc", 32'(svc_mask), 32'd0);
        check_eq("tmo_flag", 32'(timeout), 32'd1);
        pc = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        repeat (3) tick();
        check_eq("tmo_sticky", 32'(timeout), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("tmo_rst", 32'(timeout), 32'd0);
`else
        // SERVICE waits for eoi indefinitely; eoi with held request requalifies.
        repeat (20) tick();
        check_eq("wait_svc", 32'(svc_mask), 32'h0400_0000);
        check_eq("wait_tmo", 32'(timeout), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check_eq("eoi_req_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check_eq("eoi_req_e2", 32'(irq_valid), 32'd0);
        tick();
        check_eq("eoi_req_e3", 32'(irq_valid), 32'd1);
        pc = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_dispatch_seq.md
Name: irq_dispatch_seq

Overview:
- Sequential dispatch stage that sits directly downstream of the 27-channel priority interrupt encoder.
- It consumes the encoder's combinational bus flags and channel code, and filters glitches through stable-sample qualification.
- It latches a 5-bit vector ID and presents it to the CPU side with a valid/ready handshake.
- It holds an in-service mask until end-of-interrupt (EOI), so the serviced channel can be gated upstream.

Parameters:
- STABLE_CYCLES, 2, consecutive identical samples required before a request is accepted (legal range 1..15).
- TIMEOUT, 1024, cycles allowed in SERVICE before forced release (used only with IRQ_TIMEOUT_EN).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- pa  input  1  bus A wins (encoder PA).
- pb  input  1  bus B wins (encoder PB).
- pc  input  1  bus C wins (encoder PC).
- chan_n  input  4  active-low channel index 0..8 within the winning bus.
- irq_valid  output  1  vector available.
- irq_ready  input  1  CPU accepts vector.
- irq_vec  output  5  vector ID = bus*9 + chan, with A=0, B=1, C=2 (range 0..26).
- eoi  input  1  CPU end-of-interrupt pulse.
- svc_mask  output  27  one-hot in-service channel; bit = irq_vec. Upstream clears the matching request with it.
- busy  output  1  FSM not in IDLE.
- err_chan  output  1  one-cycle pulse when a request arrives with decoded chan > 8.
- timeout  output  1  sticky timeout flag; tied 0 when the feature is off.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, sample register and counters cleared. rst wins over every other input in the same cycle.
- Input sampling: {pa,pb,pc,~chan_n} is registered every cycle into samp_q.
  - req = pa|pb|pc.
  - Bus priority: A if pa, else B if pb, else C.
  - Decoded chan > 8 with req=1: the request is treated as absent, and err_chan pulses once per entry into that condition.
- FSM states: IDLE, QUALIFY, PRESENT, SERVICE.
- IDLE -> QUALIFY when samp_q holds a legal request; stab_cnt is loaded with 1.
- QUALIFY:
  - samp_q equal to the previous samp_q: stab_cnt increments.
  - samp_q differs: stab_cnt reloads to 1, or the FSM returns to IDLE if the request is gone.
  - stab_cnt == STABLE_CYCLES: latch irq_vec, go to PRESENT, irq_valid=1 from the next cycle.
- Latency: inputs constant from edge 0 give irq_valid high after edge STABLE_CYCLES+1.
- PRESENT:
  - irq_valid=1; irq_vec held constant regardless of input changes.
  - irq_valid&irq_ready: go to SERVICE; irq_valid drops next cycle; svc_mask bit irq_vec set next cycle.
  - eoi in PRESENT is ignored.
- SERVICE:
  - svc_mask is held, irq_valid=0, and input changes are ignored.
  - eoi: clear svc_mask and go to IDLE next cycle. A new request then needs full requalification.
- Simultaneous events:
  - irq_ready and eoi in the same PRESENT cycle: only the handshake is taken.
  - eoi together with a new request in SERVICE: release takes priority; qualification starts from IDLE.
- busy = (state != IDLE).
- irq_vec keeps its last value in IDLE/QUALIFY. It is only meaningful while irq_valid or svc_mask is nonzero.
- Reset in any state: immediate return to IDLE with svc_mask=0. Any in-flight vector is dropped.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT+1) runs in SERVICE.
  - Reaching TIMEOUT without eoi forces IDLE, clears svc_mask and sets timeout=1.
  - timeout stays set until rst.
  - The counter clears on entry to SERVICE.
- When undefined: no counter is built, timeout is tied 0, and SERVICE waits for eoi indefinitely.

Decomposition:
- Package irq_dispatch_pkg holds:
  - the state enum {IDLE,QUALIFY,PRESENT,SERVICE};
  - constants NUM_BUS=3, CH_PER_BUS=9, NUM_VEC=27, VEC_W=5;
  - a function computing vec = bus*CH_PER_BUS+chan.
- One sub-module, irq_stable_filter, contains samp_q, the previous-sample compare and stab_cnt. Its outputs are qualified, vec and err_chan.
- The top level holds the FSM, the handshake, svc_mask and the timeout logic.

Test Plan:
- Basic dispatch: STABLE_CYCLES=2, pb=1, chan_n=4'b1100 (chan 3) held from edge 0 -> irq_valid rises after edge 3 with irq_vec=12. With irq_ready=1, svc_mask[12]=1 next cycle. eoi pulse -> svc_mask=0 and busy=0 next cycle.
- Glitch rejection: pa toggles every cycle for 10 cycles -> irq_valid never asserts. FSM alternates IDLE/QUALIFY and stab_cnt never exceeds 1.
- Held vector: in PRESENT with irq_vec=0 (pa, chan 0), switch inputs to pc, chan 8 and hold irq_ready=0 for 5 cycles -> irq_vec stays 0. Then handshake -> svc_mask[0]=1.
- Illegal channel: pa=1, chan_n=4'b0110 (chan 9) -> single err_chan pulse, busy stays 0, no irq_valid.
- Reset mid-operation: rst=1 in SERVICE with svc_mask[26]=1 -> next cycle all outputs 0. After release, a fresh request needs full qualification.
- Timeout (IRQ_TIMEOUT_EN, TIMEOUT=8): enter SERVICE, no eoi -> after 8 cycles svc_mask=0, timeout=1. A later eoi has no effect and timeout stays set until rst.
